// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared access-width codes, responder FSM encoding and
//               byte-lane helper functions for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    // dm_ctrl access-width/extension codes, shared with the core's decoder.
    // Codes 3'b101-3'b111 fall through to word behaviour everywhere.
    localparam logic [2:0] c_DM_WORD  = 3'b000;
    localparam logic [2:0] c_DM_HALF  = 3'b001;
    localparam logic [2:0] c_DM_HALFU = 3'b010;
    localparam logic [2:0] c_DM_BYTE  = 3'b011;
    localparam logic [2:0] c_DM_BYTEU = 3'b100;

    // Wait-state FSM encoding.
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_WAIT = 2'b01;
    localparam logic [1:0] c_ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10
    } acc_width_e;

    // Collapse the extension-bearing code into a plain access width.
    function automatic acc_width_e decode_width(input logic [2:0] ctrl);
        case (ctrl)
            c_DM_HALF, c_DM_HALFU: return ACC_HALF;
            c_DM_BYTE, c_DM_BYTEU: return ACC_BYTE;
            default:               return ACC_WORD;
        endcase
    endfunction

    // Byte enables for a store of the given width at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] ctrl, input logic [1:0] off);
        case (decode_width(ctrl))
            ACC_BYTE: return 4'b0001 << off;
            ACC_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // Halfwords need an even offset, words need offset zero.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
        case (decode_width(ctrl))
            ACC_BYTE: return 1'b0;
            ACC_HALF: return off[0];
            default:  return (off != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_fmt
// Description : Combinational load lane extraction with sign/zero extension,
//               and store-data replication across byte lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_fmt
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  i_dm_ctrl,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rd_word >> {i_byte_off, 3'b000});
    assign w_half = i_byte_off[1] ? i_rd_word[31:16] : i_rd_word[15:0];

    // Select the addressed lane(s) and extend according to the code.
    always_comb begin
        o_ld_data = i_rd_word;
        case (i_dm_ctrl)
            c_DM_HALF:  o_ld_data = {{16{w_half[15]}}, w_half};
            c_DM_HALFU: o_ld_data = {16'h0000, w_half};
            c_DM_BYTE:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            c_DM_BYTEU: o_ld_data = {24'h000000, w_byte};
            default:    o_ld_data = i_rd_word;
        endcase
    end

    // Replicate right-aligned store data into every lane; the byte enables
    // then pick which lanes actually land in the array.
    always_comb begin
        o_st_word = i_st_data;
        case (decode_width(i_dm_ctrl))
            ACC_BYTE: o_st_word = {4{i_st_data[7:0]}};
            ACC_HALF: o_st_word = {2{i_st_data[15:0]}};
            default:  o_st_word = i_st_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core's MEM-stage port: word
//               array with byte-lane stores, extended loads, MIO_ready
//               handshake with optional wait states and a sticky
//               misalignment error.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [c_DEPTH];
    logic                  r_misalign_err;
    logic [31:0]           r_err_addr;

    logic [ADDR_WIDTH-1:0] w_index;
    logic [1:0]            w_off;
    logic                  w_misaligned;
    logic [3:0]            w_be;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_ld_data;
    logic [31:0]           w_st_word;
    logic                  w_we;

    // Upper address bits are dropped, so the array wraps modulo its depth.
    assign w_index      = Addr_in[ADDR_WIDTH+1:2];
    assign w_off        = Addr_in[1:0];
    assign w_misaligned = is_misaligned(dm_ctrl, w_off);
    assign w_be         = lane_mask(dm_ctrl, w_off);
    assign w_rd_word    = r_mem[w_index];

    dmem_lane_fmt u_lane_fmt (
        .i_dm_ctrl  (dm_ctrl),
        .i_byte_off (w_off),
        .i_rd_word  (w_rd_word),
        .i_st_data  (Data_in),
        .o_ld_data  (w_ld_data),
        .o_st_word  (w_st_word)
    );

    assign Data_out = (req && !w_misaligned) ? w_ld_data : 32'h0000_0000;

    // Stores land only on the edge closing the completing cycle; reset
    // suppresses the write even in the zero-wait configuration.
    assign w_we = MIO_ready && mem_w && !w_misaligned && !reset;

    // Byte-enabled write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_st_word[8*b +: 8];
                end
            end
        end
    end

    // Sticky error flag; the address is captured only for the first offender.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign_err <= 1'b0;
            r_err_addr     <= 32'h0000_0000;
        end else if (MIO_ready && w_misaligned && !r_misalign_err) begin
            r_misalign_err <= 1'b1;
            r_err_addr     <= Addr_in;
        end
    end

    assign misalign_err = r_misalign_err;
    assign err_addr     = r_err_addr;

    if (WAIT_STATES == 0) begin : g_no_wait
        assign MIO_ready = req;
    end else begin : g_wait
        // The request cycle itself counts as one of the WAIT_STATES+1 cycles,
        // so the counter holds the WAIT cycles still to go before DONE.
        localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES - 1);

        logic [1:0] r_state;
        logic [3:0] r_count;

        // IDLE -> WAIT (counting down) -> DONE -> IDLE; req drop aborts.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= c_ST_IDLE;
                r_count <= 4'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (req) begin
                            r_count <= c_WAIT_LOAD;
                            r_state <= (c_WAIT_LOAD == 4'd0) ? c_ST_DONE : c_ST_WAIT;
                        end
                    end
                    c_ST_WAIT: begin
                        if (!req) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_count <= r_count - 4'd1;
                            if (r_count == 4'd1) begin
                                r_state <= c_ST_DONE;
                            end
                        end
                    end
                    c_ST_DONE: r_state <= c_ST_IDLE;
                    default:   r_state <= c_ST_IDLE;
                endcase
            end
        end

        assign MIO_ready = (r_state == c_ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder with zero,
//               two and three wait states; load results go through a
//               scoreboard queue and are compared on MIO_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  req_v;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] din;
    logic [2:0]  ctrl;

    logic [31:0] dout0, dout2, dout3;
    logic        rdy0, rdy2, rdy3;
    logic        merr0, merr2, merr3;
    logic [31:0] eaddr0, eaddr2, eaddr3;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .mem_w(mem_w), .Addr_in(addr),
        .Data_in(din), .dm_ctrl(ctrl), .Data_out(dout0), .MIO_ready(rdy0),
        .misalign_err(merr0), .err_addr(eaddr0)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req_v[1]), .mem_w(mem_w), .Addr_in(addr),
        .Data_in(din), .dm_ctrl(ctrl), .Data_out(dout2), .MIO_ready(rdy2),
        .misalign_err(merr2), .err_addr(eaddr2)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req_v[2]), .mem_w(mem_w), .Addr_in(addr),
        .Data_in(din), .dm_ctrl(ctrl), .Data_out(dout3), .MIO_ready(rdy3),
        .misalign_err(merr3), .err_addr(eaddr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdy_of(input int sel);
        case (sel)
            0:       return rdy0;
            1:       return rdy2;
            default: return rdy3;
        endcase
    endfunction

    function automatic logic [31:0] dout_of(input int sel);
        case (sel)
            0:       return dout0;
            1:       return dout2;
            default: return dout3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on instance sel; loads push their expected data
    // when driven and pop/compare it in the MIO_ready cycle.
    task automatic access(input int sel, input logic we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic is_load, input logic [31:0] exp, input string tag);
        logic        got;
        logic [31:0] e;
        string       t;
        if (is_load) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk); #1;
        mem_w = we; addr = a; din = d; ctrl = c; req_v[sel] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (rdy_of(sel)) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_ready"}, {31'b0, got}, 32'd1);
        if (is_load) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, dout_of(sel), e);
        end
        @(posedge clk); #1;
        req_v[sel] = 1'b0;
        mem_w = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_v = 3'b000; mem_w = 1'b0;
        addr = 32'h0; din = 32'h0; ctrl = c_DM_WORD;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_dout0",  dout0, 32'h0);
        check("rst_rdy0",   {31'b0, rdy0}, 32'd0);
        check("rst_merr0",  {31'b0, merr0}, 32'd0);
        check("rst_eaddr0", eaddr0, 32'h0);
        check("rst_rdy2",   {31'b0, rdy2}, 32'd0);
        check("rst_rdy3",   {31'b0, rdy3}, 32'd0);

        // Zero wait states: word/byte stores and extended loads.
        access(0, 1, c_DM_WORD,  32'h4, 32'h12345678, 0, 0, "sw4");
        access(0, 0, c_DM_WORD,  32'h4, 32'h0, 1, 32'h12345678, "lw4");
        access(0, 1, c_DM_BYTE,  32'h5, 32'hFFFF_FFAB, 0, 0, "sb5");
        access(0, 0, c_DM_WORD,  32'h4, 32'h0, 1, 32'h1234AB78, "lw4_after_sb");
        access(0, 1, c_DM_WORD,  32'h8, 32'h00008080, 0, 0, "sw8");
        access(0, 0, c_DM_BYTE,  32'h8, 32'h0, 1, 32'hFFFFFF80, "lb8");
        access(0, 0, c_DM_BYTEU, 32'h8, 32'h0, 1, 32'h00000080, "lbu8");
        access(0, 0, c_DM_HALF,  32'h8, 32'h0, 1, 32'hFFFF8080, "lh8");
        access(0, 0, c_DM_HALFU, 32'h8, 32'h0, 1, 32'h00008080, "lhu8");
        access(0, 0, c_DM_HALF,  32'hA, 32'h0, 1, 32'h00000000, "lhA");
        access(0, 1, c_DM_BYTE,  32'hB, 32'h0000009C, 0, 0, "sbB");
        access(0, 0, 3'b111,     32'h8, 32'h0, 1, 32'h9C008080, "lw8_code7");
        access(0, 0, c_DM_BYTE,  32'hB, 32'h0, 1, 32'hFFFFFF9C, "lbB");
        access(0, 0, c_DM_HALFU, 32'hA, 32'h0, 1, 32'h00009C00, "lhuA");
        access(0, 1, c_DM_HALF,  32'hE, 32'h0000BEEF, 0, 0, "shE");
        access(0, 0, c_DM_HALF,  32'hE, 32'h0, 1, 32'hFFFFBEEF, "lhE");

        // Misalignment: no write, sticky flag, first address kept.
        access(0, 1, c_DM_WORD, 32'h6, 32'hDEADBEEF, 0, 0, "sw6_mis");
        check("mis_flag",  {31'b0, merr0}, 32'd1);
        check("mis_eaddr", eaddr0, 32'h6);
        access(0, 0, c_DM_WORD, 32'h4, 32'h0, 1, 32'h1234AB78, "lw4_after_mis");
        access(0, 0, c_DM_HALF, 32'h9, 32'h0, 1, 32'h00000000, "lh9_mis");
        check("mis_eaddr_kept", eaddr0, 32'h6);

        // Address wrap modulo depth.
        access(0, 1, c_DM_WORD, 32'h1000, 32'h00000011, 0, 0, "sw1000");
        access(0, 0, c_DM_WORD, 32'h0, 32'h0, 1, 32'h00000011, "lw0_wrap");

        // Two wait states: ready only in cycle 2, store visible only afterwards.
        access(1, 1, c_DM_WORD, 32'h10, 32'h0, 0, 0, "ws2_pre");
        @(posedge clk); #1;
        mem_w = 1'b1; addr = 32'h10; din = 32'hCAFEF00D; ctrl = c_DM_WORD; req_v[1] = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            check($sformatf("ws2_rdy_c%0d", cyc), {31'b0, rdy2}, (cyc == 2) ? 32'd1 : 32'd0);
            check($sformatf("ws2_old_c%0d", cyc), dout2, 32'h0);
        end
        @(posedge clk); #1;
        req_v[1] = 1'b0; mem_w = 1'b0;
        @(negedge clk);
        check("ws2_rdy_idle", {31'b0, rdy2}, 32'd0);
        access(1, 0, c_DM_WORD,  32'h10, 32'h0, 1, 32'hCAFEF00D, "ws2_lw");
        access(1, 0, c_DM_HALFU, 32'h12, 32'h0, 1, 32'h0000CAFE, "ws2_lhu");

        // Three wait states: abort by dropping req, then reset mid-WAIT.
        access(2, 1, c_DM_WORD, 32'h20, 32'h00000055, 0, 0, "ws3_pre");
        @(posedge clk); #1;
        mem_w = 1'b1; addr = 32'h20; din = 32'h00000077; ctrl = c_DM_WORD; req_v[2] = 1'b1;
        @(negedge clk);
        check("ws3_abort_c0", {31'b0, rdy3}, 32'd0);
        @(posedge clk); #1;
        req_v[2] = 1'b0; mem_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("ws3_abort_idle%0d", k), {31'b0, rdy3}, 32'd0);
        end
        access(2, 0, c_DM_WORD, 32'h20, 32'h0, 1, 32'h00000055, "ws3_lw_after_abort");

        @(posedge clk); #1;
        mem_w = 1'b1; addr = 32'h20; din = 32'h00000099; ctrl = c_DM_WORD; req_v[2] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ws3_rst_c1", {31'b0, rdy3}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; req_v[2] = 1'b0; mem_w = 1'b0;
        @(negedge clk);
        check("ws3_rst_rdy",   {31'b0, rdy3}, 32'd0);
        check("rst_clr_merr0", {31'b0, merr0}, 32'd0);
        check("rst_clr_eaddr", eaddr0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("ws3_post_rst%0d", k), {31'b0, rdy3}, 32'd0);
        end
        access(2, 0, c_DM_WORD, 32'h20, 32'h0, 1, 32'h00000055, "ws3_lw_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
